// File: rtl/ram_port_arbiter_d1.sv
// ram_port_arbiter_d1: two-requester arbiter in front of a single-port RAM.
//   Grants at most one requester per cycle and forwards its address, data and
//   write enable to the RAM in the same cycle. A granted read returns a
//   one-cycle response in the next cycle, carrying ram_dout.
// Build option: define ARB_FIXED_PRIO_EN to make requester 0 always win
//   contention. The default build uses round-robin on a last_grant register.
// Ports:
//   clock, reset              rising-edge clock, synchronous active-high reset
//   reqN_valid/we/addr/din    request from requester N (N = 0, 1)
//   reqN_ready                combinational grant for requester N
//   rspN_valid/rspN_data      read response for requester N
//   ram_addr/ram_din/ram_we   RAM command, valid in the grant cycle
//   ram_dout                  RAM read data (registered-address RAM)
module ram_port_arbiter_d1 #(
  parameter int unsigned AWIDTH = 3,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_din,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DWIDTH-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_din,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DWIDTH-1:0] rsp1_data,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  logic              grant0, grant1;
  logic [AWIDTH-1:0] addr_hold_q, addr_hold_d;
  logic [DWIDTH-1:0] din_hold_q, din_hold_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;

`ifndef ARB_FIXED_PRIO_EN
  logic last_grant_q, last_grant_d;
`endif

  // Grant selection; nothing is granted while reset is high.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (req0_valid && !req1_valid) begin
        grant0 = 1'b1;
      end else if (!req0_valid && req1_valid) begin
        grant1 = 1'b1;
      end else if (req0_valid && req1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
        grant0 = 1'b1;
`else
        // Contention: the requester that did not win last time goes next.
        if (last_grant_q) grant0 = 1'b1;
        else              grant1 = 1'b1;
`endif
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // RAM command: granted request this cycle, otherwise the last driven values.
  always_comb begin
    addr_hold_d = addr_hold_q;
    din_hold_d  = din_hold_q;
    ram_we      = 1'b0;
    if (grant0) begin
      addr_hold_d = req0_addr;
      din_hold_d  = req0_din;
      ram_we      = req0_we;
    end else if (grant1) begin
      addr_hold_d = req1_addr;
      din_hold_d  = req1_din;
      ram_we      = req1_we;
    end
  end

  // The hold registers clear on the reset edge; force zero during the first
  // reset cycle as well.
  assign ram_addr = reset ? '0 : addr_hold_d;
  assign ram_din  = reset ? '0 : din_hold_d;

  // A granted read answers in the following cycle, when ram_dout is valid.
  assign rsp_valid_d = {grant1 & ~req1_we, grant0 & ~req0_we};

`ifndef ARB_FIXED_PRIO_EN
  assign last_grant_d = grant1 ? 1'b1 : (grant0 ? 1'b0 : last_grant_q);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_hold_q  <= '0;
      din_hold_q   <= '0;
      rsp_valid_q  <= 2'b00;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      addr_hold_q  <= addr_hold_d;
      din_hold_q   <= din_hold_d;
      rsp_valid_q  <= rsp_valid_d;
`ifndef ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Reset in the response cycle suppresses a pending response immediately.
  assign rsp0_valid = rsp_valid_q[0] & ~reset;
  assign rsp1_valid = rsp_valid_q[1] & ~reset;
  assign rsp0_data  = ram_dout;
  assign rsp1_data  = ram_dout;

endmodule

// File: tb/tb_ram_port_arbiter_d1.sv
// Testbench for ram_port_arbiter_d1 (default round-robin build) with a
// behavioural registered-address RAM attached to the RAM-side ports.
module tb_ram_port_arbiter_d1;

  localparam int unsigned AW = 3;
  localparam int unsigned DW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_valid, req0_we, req1_valid, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_din, req1_din;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_data, rsp1_data;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_we;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  ram_port_arbiter_d1 #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_din(req0_din), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_din(req1_din), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout)
  );

  // RAM model: write on the edge, read data from the address of the last edge.
  logic [DW-1:0] mem [8];
  logic [AW-1:0] raddr_q;
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'h1000 + 32'(i);
    raddr_q = '0;
  end
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    raddr_q <= ram_addr;
  end
  assign ram_dout = mem[raddr_q];

  typedef struct {
    logic          v0, we0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic          v1, we1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic          e_r0, e_r1, e_we; logic [AW-1:0] e_addr; logic [DW-1:0] e_din;
    logic          e_rv0, e_rv1; logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_din = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_din = d1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_cmd(input string tag, input logic r0, r1, we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] din,
                           input logic rv0, rv1);
    check({tag, " req0_ready"}, DW'(req0_ready), DW'(r0));
    check({tag, " req1_ready"}, DW'(req1_ready), DW'(r1));
    check({tag, " ram_we"},     DW'(ram_we),     DW'(we));
    check({tag, " ram_addr"},   DW'(ram_addr),   DW'(addr));
    check({tag, " ram_din"},    ram_din,         din);
    check({tag, " rsp0_valid"}, DW'(rsp0_valid), DW'(rv0));
    check({tag, " rsp1_valid"}, DW'(rsp1_valid), DW'(rv1));
  endtask

  initial begin
    // Contended reads, write-then-read, single requester, contended write.
    vecs[0]  = '{1,0,3'd0,32'hA0, 1,0,3'd1,32'hB1, 1,0,0,3'd0,32'hA0,        0,0,32'h0};
    vecs[1]  = '{1,0,3'd0,32'hA0, 1,0,3'd1,32'hB1, 0,1,0,3'd1,32'hB1,        1,0,32'h1000};
    vecs[2]  = '{1,0,3'd0,32'hA0, 1,0,3'd1,32'hB1, 1,0,0,3'd0,32'hA0,        0,1,32'h1001};
    vecs[3]  = '{1,0,3'd0,32'hA0, 1,0,3'd1,32'hB1, 0,1,0,3'd1,32'hB1,        1,0,32'h1000};
    vecs[4]  = '{1,1,3'd5,32'hDEADBEEF, 0,0,3'd0,32'h0, 1,0,1,3'd5,32'hDEADBEEF, 0,1,32'h1001};
    vecs[5]  = '{0,0,3'd0,32'h0, 1,0,3'd5,32'hB1,  0,1,0,3'd5,32'hB1,        0,0,32'h0};
    vecs[6]  = '{0,0,3'd0,32'h0, 0,0,3'd0,32'h0,   0,0,0,3'd5,32'hB1,        0,1,32'hDEADBEEF};
    vecs[7]  = '{0,0,3'd0,32'h0, 0,0,3'd0,32'h0,   0,0,0,3'd5,32'hB1,        0,0,32'h0};
    vecs[8]  = '{0,0,3'd0,32'h0, 1,0,3'd2,32'hB1,  0,1,0,3'd2,32'hB1,        0,0,32'h0};
    vecs[9]  = '{0,0,3'd0,32'h0, 1,0,3'd3,32'hB1,  0,1,0,3'd3,32'hB1,        0,1,32'h1002};
    vecs[10] = '{1,1,3'd7,32'h77, 1,0,3'd4,32'hB1, 1,0,1,3'd7,32'h77,        0,1,32'h1003};
    vecs[11] = '{1,1,3'd7,32'h77, 1,0,3'd4,32'hB1, 0,1,0,3'd4,32'hB1,        0,0,32'h0};
    vecs[12] = '{0,0,3'd0,32'h0, 0,0,3'd0,32'h0,   0,0,0,3'd4,32'hB1,        0,1,32'h1004};

    // Reset with both requesters asserting valid: nothing may be granted.
    reset = 1'b1;
    drive(1, 1, 3'd6, 32'h55, 1, 1, 3'd2, 32'h66);
    next_cycle();
    next_cycle();
    check_cmd("reset", 0, 0, 0, 3'd0, 32'h0, 0, 0);

    // Table vectors; the first one is applied in the first cycle out of reset.
    reset = 1'b0;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
      @(negedge clock);
      check_cmd($sformatf("vec%0d", i), vecs[i].e_r0, vecs[i].e_r1, vecs[i].e_we,
                vecs[i].e_addr, vecs[i].e_din, vecs[i].e_rv0, vecs[i].e_rv1);
      if (vecs[i].e_rv0) check($sformatf("vec%0d rsp0_data", i), rsp0_data, vecs[i].e_rdata);
      if (vecs[i].e_rv1) check($sformatf("vec%0d rsp1_data", i), rsp1_data, vecs[i].e_rdata);
      next_cycle();
    end

    // Read granted, then reset in the response cycle: response suppressed.
    drive(0, 0, 3'd0, 32'h0, 1, 0, 3'd6, 32'hB1);
    @(negedge clock);
    check("rst_seq grant req1_ready", DW'(req1_ready), DW'(1'b1));
    next_cycle();
    reset = 1'b1;
    drive(1, 0, 3'd3, 32'hA0, 1, 0, 3'd6, 32'hB1);
    @(negedge clock);
    check_cmd("rst_seq reset", 0, 0, 0, 3'd0, 32'h0, 0, 0);
    next_cycle();

    // First contended cycle after reset goes to requester 0.
    reset = 1'b0;
    @(negedge clock);
    check_cmd("rst_seq contend", 1, 0, 0, 3'd3, 32'hA0, 0, 0);
    next_cycle();

    // Idle for 5 cycles: command holds, one response from the read above.
    drive(0, 0, 3'd0, 32'h0, 0, 0, 3'd0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_cmd($sformatf("idle%0d", i), 0, 0, 0, 3'd3, 32'hA0, i == 0, 0);
      if (i == 0) check("idle0 rsp0_data", rsp0_data, 32'h1003);
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
